// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants, encodings and branch helper
package core_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10
  } resultsrc_e;

  function automatic logic branch_taken(input logic jump, input logic branch, input logic zero);
    return jump | (branch & zero);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-to-execute bundle with hazard and ALU feedback
interface id_ex_stage_if #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int RA_W = core_pkg::RA_W
);
  logic            stall_e, flush_e;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
  logic [RA_W-1:0] rs1_d, rs2_d, rd_d;
  logic            regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d;
  logic [1:0]      resultsrc_d;
  logic [2:0]      alucontrol_d;
  logic [1:0]      forward_a_e, forward_b_e;
  logic [XLEN-1:0] aluresult_m, result_w;
  logic            zero_e;

  logic [XLEN-1:0] src_a_e, src_b_e, write_data_e, pc_plus4_e, pc_target_e;
  logic [2:0]      alucontrol_e;
  logic [RA_W-1:0] rs1_e, rs2_e, rd_e;
  logic            regwrite_e, memwrite_e, pcsrc_e;
  logic [1:0]      resultsrc_e;

  modport slave (
    input  stall_e, flush_e, rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d,
           rs1_d, rs2_d, rd_d, regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d,
           resultsrc_d, alucontrol_d, forward_a_e, forward_b_e, aluresult_m, result_w, zero_e,
    output src_a_e, src_b_e, write_data_e, pc_plus4_e, pc_target_e, alucontrol_e,
           rs1_e, rs2_e, rd_e, regwrite_e, memwrite_e, pcsrc_e, resultsrc_e
  );

  modport master (
    output stall_e, flush_e, rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d,
           rs1_d, rs2_d, rd_d, regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d,
           resultsrc_d, alucontrol_d, forward_a_e, forward_b_e, aluresult_m, result_w, zero_e,
    input  src_a_e, src_b_e, write_data_e, pc_plus4_e, pc_target_e, alucontrol_e,
           rs1_e, rs2_e, rd_e, regwrite_e, memwrite_e, pcsrc_e, resultsrc_e
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux3.sv
// rtl/id_ex_stage_fwd_mux3.sv - 3:1 operand forwarding mux keyed on FWD_* selects
module fwd_mux3
  import core_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] rf,
  input  logic [W-1:0] wb,
  input  logic [W-1:0] mem,
  output logic [W-1:0] y
);
  // The unused 2'b11 encoding falls back to register-file data.
  always_comb begin
    y = rf;
    case (sel)
      FWD_WB:  y = wb;
      FWD_MEM: y = mem;
      default: y = rf;
    endcase
  end
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, operand select and branch resolve
module id_ex_stage #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int RA_W = core_pkg::RA_W
) (
  input logic           clk,
  input logic           reset,
  id_ex_stage_if.slave  bus
);
  import core_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] rd1, rd2, imm_ext, pc, pc_plus4;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic            regwrite, memwrite, jump, branch, alusrc;
    logic [1:0]      resultsrc;
    logic [2:0]      alucontrol;
  } idex_t;

  idex_t d, q;
  logic [XLEN-1:0] fwd_a, fwd_b;

  always_comb begin
    d            = '0;
    d.rd1        = bus.rd1_d;
    d.rd2        = bus.rd2_d;
    d.imm_ext    = bus.imm_ext_d;
    d.pc         = bus.pc_d;
    d.pc_plus4   = bus.pc_plus4_d;
    d.rs1        = bus.rs1_d;
    d.rs2        = bus.rs2_d;
    d.rd         = bus.rd_d;
    d.regwrite   = bus.regwrite_d;
    d.memwrite   = bus.memwrite_d;
    d.jump       = bus.jump_d;
    d.branch     = bus.branch_d;
    d.alusrc     = bus.alusrc_d;
    d.resultsrc  = bus.resultsrc_d;
    d.alucontrol = bus.alucontrol_d;
  end

  // An all-zero entry is the bubble: add x0,x0,x0 with no side effects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             q <= '0;
    else if (bus.flush_e)  q <= '0;
    else if (!bus.stall_e) q <= d;
  end

  fwd_mux3 #(.W(XLEN)) u_fwd_a (
    .sel (bus.forward_a_e),
    .rf  (q.rd1),
    .wb  (bus.result_w),
    .mem (bus.aluresult_m),
    .y   (fwd_a)
  );

  fwd_mux3 #(.W(XLEN)) u_fwd_b (
    .sel (bus.forward_b_e),
    .rf  (q.rd2),
    .wb  (bus.result_w),
    .mem (bus.aluresult_m),
    .y   (fwd_b)
  );

  assign bus.src_a_e      = fwd_a;
  assign bus.write_data_e = fwd_b;
  assign bus.src_b_e      = q.alusrc ? q.imm_ext : fwd_b;
  assign bus.pc_target_e  = q.pc + q.imm_ext;
  assign bus.pcsrc_e      = branch_taken(q.jump, q.branch, bus.zero_e);
  assign bus.alucontrol_e = q.alucontrol;
  assign bus.pc_plus4_e   = q.pc_plus4;
  assign bus.rs1_e        = q.rs1;
  assign bus.rs2_e        = q.rs2;
  assign bus.rd_e         = q.rd;
  assign bus.regwrite_e   = q.regwrite;
  assign bus.memwrite_e   = q.memwrite;
  assign bus.resultsrc_e  = q.resultsrc;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();
  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] a, b, wd, tgt;
    logic        pcsrc, regwrite, memwrite;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    bus.stall_e = 0; bus.flush_e = 0;
    bus.rd1_d = 0; bus.rd2_d = 0; bus.imm_ext_d = 0; bus.pc_d = 0; bus.pc_plus4_d = 0;
    bus.rs1_d = 0; bus.rs2_d = 0; bus.rd_d = 0;
    bus.regwrite_d = 0; bus.memwrite_d = 0; bus.jump_d = 0; bus.branch_d = 0; bus.alusrc_d = 0;
    bus.resultsrc_d = 0; bus.alucontrol_d = 0;
    bus.forward_a_e = 0; bus.forward_b_e = 0; bus.aluresult_m = 0; bus.result_w = 0; bus.zero_e = 0;
  endtask

  task automatic test_reset;
    drive_idle();
    reset = 1;
    sb.push_back('{a:0, b:0, wd:0, tgt:0, pcsrc:0, regwrite:0, memwrite:0, rd:0});
    tick();
    e = sb.pop_front();
    checks++; if (bus.src_a_e !== e.a) begin errors++; $display("FAIL por_src_a: got %h expected %h", bus.src_a_e, e.a); end
    checks++; if (bus.pc_target_e !== e.tgt) begin errors++; $display("FAIL por_pc_target: got %h expected %h", bus.pc_target_e, e.tgt); end
    @(negedge clk) reset = 0;
    bus.rd1_d = 32'h11; bus.rd2_d = 32'h22; bus.imm_ext_d = 4; bus.pc_d = 8; bus.rd_d = 5;
    bus.jump_d = 1; bus.regwrite_d = 1; bus.memwrite_d = 1;
    tick();
    bus.stall_e = 1;
    #2 reset = 1;
    sb.push_back('{a:0, b:0, wd:0, tgt:0, pcsrc:0, regwrite:0, memwrite:0, rd:0});
    #1;
    e = sb.pop_front();
    checks++; if (bus.src_a_e !== e.a) begin errors++; $display("FAIL rst_src_a: got %h expected %h", bus.src_a_e, e.a); end
    checks++; if (bus.src_b_e !== e.b) begin errors++; $display("FAIL rst_src_b: got %h expected %h", bus.src_b_e, e.b); end
    checks++; if (bus.pcsrc_e !== e.pcsrc) begin errors++; $display("FAIL rst_pcsrc: got %b expected %b", bus.pcsrc_e, e.pcsrc); end
    checks++; if (bus.pc_target_e !== e.tgt) begin errors++; $display("FAIL rst_pc_target: got %h expected %h", bus.pc_target_e, e.tgt); end
    checks++; if ({bus.regwrite_e, bus.memwrite_e, bus.rd_e} !== {e.regwrite, e.memwrite, e.rd}) begin
      errors++; $display("FAIL rst_ctrl: got %b expected %b", {bus.regwrite_e, bus.memwrite_e, bus.rd_e}, {e.regwrite, e.memwrite, e.rd}); end
    @(negedge clk) reset = 0;
    drive_idle();
  endtask

  task automatic test_load_forward;
    bus.rd1_d = 5; bus.rd2_d = 7; bus.alusrc_d = 0; bus.rd_d = 3; bus.regwrite_d = 1;
    sb.push_back('{a:5, b:7, wd:7, tgt:0, pcsrc:0, regwrite:1, memwrite:0, rd:3});
    tick();
    e = sb.pop_front();
    checks++; if (bus.src_a_e !== e.a) begin errors++; $display("FAIL load_src_a: got %h expected %h", bus.src_a_e, e.a); end
    checks++; if (bus.src_b_e !== e.b) begin errors++; $display("FAIL load_src_b: got %h expected %h", bus.src_b_e, e.b); end
    checks++; if (bus.write_data_e !== e.wd) begin errors++; $display("FAIL load_wd: got %h expected %h", bus.write_data_e, e.wd); end
    checks++; if (bus.rd_e !== e.rd) begin errors++; $display("FAIL load_rd: got %h expected %h", bus.rd_e, e.rd); end
    bus.forward_a_e = FWD_MEM; bus.aluresult_m = 32'h100; bus.forward_b_e = FWD_WB; bus.result_w = 32'h20;
    sb.push_back('{a:32'h100, b:32'h20, wd:32'h20, tgt:0, pcsrc:0, regwrite:1, memwrite:0, rd:3});
    #1;
    e = sb.pop_front();
    checks++; if (bus.src_a_e !== e.a) begin errors++; $display("FAIL fwd_src_a: got %h expected %h", bus.src_a_e, e.a); end
    checks++; if (bus.src_b_e !== e.b) begin errors++; $display("FAIL fwd_src_b: got %h expected %h", bus.src_b_e, e.b); end
    checks++; if (bus.write_data_e !== e.wd) begin errors++; $display("FAIL fwd_wd: got %h expected %h", bus.write_data_e, e.wd); end
    bus.forward_b_e = 2'b11;
    sb.push_back('{a:32'h100, b:7, wd:7, tgt:0, pcsrc:0, regwrite:1, memwrite:0, rd:3});
    #1;
    e = sb.pop_front();
    checks++; if (bus.src_b_e !== e.b) begin errors++; $display("FAIL fwd11_src_b: got %h expected %h", bus.src_b_e, e.b); end
    checks++; if (bus.write_data_e !== e.wd) begin errors++; $display("FAIL fwd11_wd: got %h expected %h", bus.write_data_e, e.wd); end
    drive_idle();
  endtask

  task automatic test_imm;
    bus.alusrc_d = 1; bus.imm_ext_d = 32'hFFFF_FFFC; bus.pc_d = 32'h2; bus.rd2_d = 7;
    sb.push_back('{a:0, b:32'hFFFF_FFFC, wd:7, tgt:32'hFFFF_FFFE, pcsrc:0, regwrite:0, memwrite:0, rd:0});
    tick();
    e = sb.pop_front();
    checks++; if (bus.src_b_e !== e.b) begin errors++; $display("FAIL imm_src_b: got %h expected %h", bus.src_b_e, e.b); end
    checks++; if (bus.write_data_e !== e.wd) begin errors++; $display("FAIL imm_wd: got %h expected %h", bus.write_data_e, e.wd); end
    checks++; if (bus.pc_target_e !== e.tgt) begin errors++; $display("FAIL imm_pc_target: got %h expected %h", bus.pc_target_e, e.tgt); end
    drive_idle();
  endtask

  task automatic test_branch;
    bus.branch_d = 1; bus.pc_d = 32'hFFFF_FFF0; bus.imm_ext_d = 32'h20;
    sb.push_back('{a:0, b:0, wd:0, tgt:32'h10, pcsrc:1, regwrite:0, memwrite:0, rd:0});
    tick();
    bus.zero_e = 1; #1;
    e = sb.pop_front();
    checks++; if (bus.pc_target_e !== e.tgt) begin errors++; $display("FAIL br_wrap_target: got %h expected %h", bus.pc_target_e, e.tgt); end
    checks++; if (bus.pcsrc_e !== e.pcsrc) begin errors++; $display("FAIL br_taken: got %b expected %b", bus.pcsrc_e, e.pcsrc); end
    bus.zero_e = 0;
    sb.push_back('{a:0, b:0, wd:0, tgt:32'h10, pcsrc:0, regwrite:0, memwrite:0, rd:0});
    #1;
    e = sb.pop_front();
    checks++; if (bus.pcsrc_e !== e.pcsrc) begin errors++; $display("FAIL br_not_taken: got %b expected %b", bus.pcsrc_e, e.pcsrc); end
    bus.branch_d = 0; bus.jump_d = 1;
    for (int z = 0; z < 2; z++) sb.push_back('{a:0, b:0, wd:0, tgt:32'h10, pcsrc:1, regwrite:0, memwrite:0, rd:0});
    tick();
    for (int z = 0; z < 2; z++) begin
      bus.zero_e = z[0]; #1;
      e = sb.pop_front();
      checks++; if (bus.pcsrc_e !== e.pcsrc) begin errors++; $display("FAIL jump_zero%0d: got %b expected %b", z, bus.pcsrc_e, e.pcsrc); end
    end
    drive_idle();
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1, r2;
    logic [4:0]  rd;
    for (int i = 0; i < 4; i++) begin
      r1 = $urandom; r2 = $urandom; rd = 5'($urandom_range(1, 31));
      bus.rd1_d = r1; bus.rd2_d = r2; bus.rd_d = rd; bus.regwrite_d = i[0]; bus.memwrite_d = ~i[0];
      sb.push_back('{a:r1, b:r2, wd:r2, tgt:0, pcsrc:0, regwrite:i[0], memwrite:~i[0], rd:rd});
      tick();
      e = sb.pop_front();
      checks++; if ({bus.src_a_e, bus.src_b_e, bus.rd_e, bus.regwrite_e, bus.memwrite_e} !== {e.a, e.b, e.rd, e.regwrite, e.memwrite}) begin
        errors++; $display("FAIL b2b_%0d: got a=%h b=%h rd=%0d rw=%b mw=%b expected a=%h b=%h rd=%0d rw=%b mw=%b", i,
          bus.src_a_e, bus.src_b_e, bus.rd_e, bus.regwrite_e, bus.memwrite_e, e.a, e.b, e.rd, e.regwrite, e.memwrite); end
    end
    drive_idle();
  endtask

  task automatic test_stall_flush;
    bus.rd1_d = 32'hAA; bus.rd2_d = 32'hBB; bus.rd_d = 9; bus.regwrite_d = 1; bus.memwrite_d = 1;
    bus.pc_d = 32'h40; bus.imm_ext_d = 32'h8;
    tick();
    bus.stall_e = 1;
    for (int i = 0; i < 3; i++) begin
      bus.rd1_d = $urandom; bus.rd2_d = $urandom; bus.rd_d = 5'($urandom); bus.regwrite_d = 0; bus.pc_d = $urandom;
      sb.push_back('{a:32'hAA, b:32'hBB, wd:32'hBB, tgt:32'h48, pcsrc:0, regwrite:1, memwrite:1, rd:9});
      tick();
      e = sb.pop_front();
      checks++; if ({bus.src_a_e, bus.src_b_e, bus.pc_target_e, bus.rd_e, bus.regwrite_e} !== {e.a, e.b, e.tgt, e.rd, e.regwrite}) begin
        errors++; $display("FAIL stall_hold_%0d: got a=%h b=%h tgt=%h rd=%0d rw=%b expected a=%h b=%h tgt=%h rd=%0d rw=%b", i,
          bus.src_a_e, bus.src_b_e, bus.pc_target_e, bus.rd_e, bus.regwrite_e, e.a, e.b, e.tgt, e.rd, e.regwrite); end
    end
    bus.flush_e = 1; bus.regwrite_d = 1; bus.memwrite_d = 1; bus.jump_d = 1;
    sb.push_back('{a:0, b:0, wd:0, tgt:0, pcsrc:0, regwrite:0, memwrite:0, rd:0});
    tick();
    e = sb.pop_front();
    checks++; if ({bus.src_a_e, bus.src_b_e, bus.pc_target_e, bus.rd_e} !== {e.a, e.b, e.tgt, e.rd}) begin
      errors++; $display("FAIL flush_data: got a=%h b=%h tgt=%h rd=%0d expected zero", bus.src_a_e, bus.src_b_e, bus.pc_target_e, bus.rd_e); end
    checks++; if ({bus.regwrite_e, bus.memwrite_e, bus.pcsrc_e} !== {e.regwrite, e.memwrite, e.pcsrc}) begin
      errors++; $display("FAIL flush_ctrl: got %b expected %b", {bus.regwrite_e, bus.memwrite_e, bus.pcsrc_e}, {e.regwrite, e.memwrite, e.pcsrc}); end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_load_forward();
    test_imm();
    test_branch();
    test_back_to_back();
    test_stall_flush();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus execute-side operand steering for the 5-stage RV32 core.
- Captures decoded fields at clock edge; combinationally applies forwarding and immediate select to produce the ALU operands (a, b, alucontrol).
- Consumes the ALU zero flag to resolve branches/jumps (pcsrc_e, pc_target_e) for the fetch stage.
- Sits between the decode stage and the ALU; feeds the EX/MEM register.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall_e  in  1  hold all ID/EX registers
- flush_e  in  1  insert bubble at next edge
- rd1_d, rd2_d  in  XLEN  register-file read data
- imm_ext_d  in  XLEN  extended immediate
- pc_d, pc_plus4_d  in  XLEN  decode PC and PC+4
- rs1_d, rs2_d, rd_d  in  RA_W  register addresses
- regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d  in  1  decoded controls
- resultsrc_d  in  2  writeback select
- alucontrol_d  in  3  ALU op (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt)
- forward_a_e, forward_b_e  in  2  forwarding selects from hazard unit
- aluresult_m  in  XLEN  MEM-stage ALU result
- result_w  in  XLEN  WB-stage result
- zero_e  in  1  ALU zero flag
- src_a_e, src_b_e  out  XLEN  ALU operands a, b
- alucontrol_e  out  3  to ALU
- write_data_e  out  XLEN  forwarded rs2 data for store
- rs1_e, rs2_e, rd_e  out  RA_W  to hazard unit / EX/MEM
- regwrite_e, memwrite_e, resultsrc_e  out  1/1/2  to EX/MEM
- pc_plus4_e  out  XLEN  to EX/MEM
- pc_target_e  out  XLEN  branch/jump target
- pcsrc_e  out  1  redirect fetch

Behaviour:
- Reset (async, active-high): every registered field is 0 immediately; hence src_a_e = 0, src_b_e = 0 (alusrc = 0, forward = 00), pcsrc_e = 0, pc_target_e = 0, all controls 0.
- Priority at posedge: reset > flush_e > stall_e > load.
- Load: every *_d input is captured into its *_e register; 1-cycle latency.
- flush_e = 1: all registers cleared to 0 (bubble = add x0,x0,x0 with regwrite/memwrite/jump/branch = 0).
- stall_e = 1 and flush_e = 0: all registers hold their values.
- Forwarding, combinational on registered data: 00 -> rdX_e; 01 -> result_w; 10 -> aluresult_m; 11 reserved, treated as 00.
- src_a_e = fwdA.
- write_data_e = fwdB.
- src_b_e = alusrc_e ? imm_ext_e : fwdB.
- pc_target_e = pc_e + imm_ext_e, modulo 2^XLEN (wraps; no carry out).
- pcsrc_e = jump_e | (branch_e & zero_e); combinational, same cycle as the ALU result.
- Forward selects act on the current registered instruction only; they are never registered.
- Reset mid-stall: reset wins and clears all fields.
- Flush and stall together: flush wins.

Decomposition:
- Shared package core_pkg:
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - ALU op constants (ALU_ADD … ALU_SLT).
  - RESULTSRC encodings (ALU = 00, MEM = 01, PC+4 = 10).
  - XLEN.
- One sub-module: fwd_mux3 (XLEN-wide 3:1 mux keyed on FWD_*; 11 falls back to FWD_RF), instantiated twice.

Test Plan:
- Reset asserted mid-run with nonzero fields latched -> all outputs 0 without waiting for a clock edge; pcsrc_e = 0.
- Load rd1_d = 5, rd2_d = 7, alusrc_d = 0, fwd = 00 -> next cycle src_a_e = 5, src_b_e = 7, write_data_e = 7.
- Same instruction with forward_a_e = 10, aluresult_m = 0x100, forward_b_e = 01, result_w = 0x20 -> src_a_e = 0x100, src_b_e = 0x20, write_data_e = 0x20. Then forward_b_e = 11 -> src_b_e = 7.
- alusrc_d = 1, imm_ext_d = 0xFFFFFFFC, pc_d = 0x00000002 -> src_b_e = 0xFFFFFFFC; pc_target_e = 0xFFFFFFFE.
- Branch wrap case: branch_d = 1, pc_d = 0xFFFFFFF0, imm = 0x20 -> pc_target_e = 0x00000010. With zero_e = 1, pcsrc_e = 1; with zero_e = 0, pcsrc_e = 0. With jump_d = 1, pcsrc_e = 1 regardless of zero_e.
- Stall then flush: stall_e = 1 holds the prior instruction across 3 edges while *_d changes. Then stall_e = 1 and flush_e = 1 together -> all fields 0, regwrite_e = 0, memwrite_e = 0.
